operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 52 +++++
 rtl/operand_fetch.sv | 96 +++++++++
 tb/tb_operand_fetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: issue handshake, operand bundle, writeback and regfile ports.
// The slave modport is the fetch stage; the master modport is its environment.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_has_rd;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [4:0]  out_rd;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  logic [4:0]  rf_rreg1;
  logic [4:0]  rf_rreg2;
  logic [63:0] rf_rdata1;
  logic [63:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [63:0] rf_wdata;

  logic        wb_err;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_has_rd,
    output out_ready,
    output wb_valid, wb_rd, wb_data,
    output rf_rdata1, rf_rdata2,
    input  in_ready,
    input  out_valid, out_a, out_b, out_rd,
    input  rf_rreg1, rf_rreg2, rf_we, rf_wreg, rf_wdata,
    input  wb_err
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_has_rd,
    input  out_ready,
    input  wb_valid, wb_rd, wb_data,
    input  rf_rdata1, rf_rdata2,
    output in_ready,
    output out_valid, out_a, out_b, out_rd,
    output rf_rreg1, rf_rreg2, rf_we, rf_wreg, rf_wdata,
    output wb_err
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded source resolution with writeback bypass,
// a one-entry output register and a sticky stray-writeback flag.
module operand_fetch (
  input  logic           clk,
  input  logic           reset,
  operand_fetch_if.slave bus
);
  localparam logic [4:0] ZeroReg = 5'd31;

  logic [31:0] busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;

  logic        wb_we;
  logic        byp1, byp2;
  logic        rs1_ok, rs2_ok;
  logic        hazard, ready, accept;
  logic [63:0] opa, opb;

  assign bus.rf_rreg1 = bus.in_rs1;
  assign bus.rf_rreg2 = bus.in_rs2;
  assign wb_we        = bus.wb_valid && (bus.wb_rd != ZeroReg);
  assign bus.rf_we    = wb_we;
  assign bus.rf_wreg  = bus.wb_rd;
  assign bus.rf_wdata = bus.wb_data;

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_rd    = rd_q;
  assign bus.wb_err    = err_q;

  // A writeback landing this cycle resolves a busy source via the bypass.
  always_comb begin
    byp1   = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
    byp2   = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
    rs1_ok = (bus.in_rs1 == ZeroReg) || !busy_q[bus.in_rs1] || byp1;
    rs2_ok = (bus.in_rs2 == ZeroReg) || !busy_q[bus.in_rs2] || byp2;
    hazard = bus.in_valid && !(rs1_ok && rs2_ok);
    ready  = !hazard && (!valid_q || bus.out_ready);
    accept = bus.in_valid && ready;

    if (bus.in_rs1 == ZeroReg) opa = 64'd0;
    else if (byp1)             opa = bus.wb_data;
    else                       opa = bus.rf_rdata1;

    if (bus.in_rs2 == ZeroReg) opb = 64'd0;
    else if (byp2)             opb = bus.wb_data;
    else                       opb = bus.rf_rdata2;
  end

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    err_d   = err_q || (wb_we && !busy_q[bus.wb_rd]);

    // Clear before set so a new writer issued on the same edge stays pending.
    if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
    if (accept && bus.in_has_rd && (bus.in_rd != ZeroReg)) busy_d[bus.in_rd] = 1'b1;
    busy_d[31] = 1'b0;

    if (accept) begin
      valid_d = 1'b1;
      a_d     = opa;
      b_d     = opb;
      rd_d    = bus.in_rd;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios then random traffic
// against a register-array reference model.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if bus();
  operand_fetch dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy[32];
  bit          m_valid;
  logic [63:0] m_a, m_b;
  logic [4:0]  m_rd;
  bit          m_err;

  function automatic bit m_resolvable(logic [4:0] r);
    return (r == 5'd31) || !m_busy[r] || (bus.wb_valid && bus.wb_rd == r);
  endfunction

  function automatic logic [63:0] m_operand(logic [4:0] r, logic [63:0] rdata);
    if (r == 5'd31) return 64'd0;
    if (bus.wb_valid && bus.wb_rd == r) return bus.wb_data;
    return rdata;
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = bus.in_valid && !(m_resolvable(bus.in_rs1) && m_resolvable(bus.in_rs2));
    return !hz && (!m_valid || bus.out_ready);
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_err = 1'b0;
  endtask

  task automatic model_clock();
    bit acc;
    logic [63:0] na, nb;
    acc = bus.in_valid && m_ready();
    na  = m_operand(bus.in_rs1, bus.rf_rdata1);
    nb  = m_operand(bus.in_rs2, bus.rf_rdata2);
    if (bus.wb_valid && bus.wb_rd != 5'd31) begin
      if (!m_busy[bus.wb_rd]) m_err = 1'b1;
      m_busy[bus.wb_rd] = 1'b0;
    end
    if (acc && bus.in_has_rd && bus.in_rd != 5'd31) m_busy[bus.in_rd] = 1'b1;
    if (acc) begin
      m_valid = 1'b1; m_a = na; m_b = nb; m_rd = bus.in_rd;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_has_rd = 0;
    bus.out_ready = 1; bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit has_rd, input logic [63:0] d1, input logic [63:0] d2);
    bus.in_valid = 1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_has_rd = has_rd; bus.rf_rdata1 = d1; bus.rf_rdata2 = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.in_rs1 = 5'd6; bus.in_rs2 = 5'd12;
    model_reset();
    #3;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_a !== 64'd0 || bus.out_b !== 64'd0 || bus.out_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_bundle got a=%h b=%h rd=%0d want zeros", bus.out_a, bus.out_b, bus.out_rd); end
    n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err got %0b want 0", bus.wb_err); end
    n_checks++; if (bus.rf_rreg1 !== 5'd6 || bus.rf_rreg2 !== 5'd12) begin
      n_fail++; $display("FAIL reset_rf_rreg got %0d/%0d want 6/12", bus.rf_rreg1, bus.rf_rreg2); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    idle_inputs();
    issue(5'd3, 5'd4, 5'd10, 0, 64'h11, 64'h22);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %0b want 1", bus.in_ready); end
    n_checks++; if (bus.rf_rreg1 !== 5'd3 || bus.rf_rreg2 !== 5'd4) begin
      n_fail++; $display("FAIL basic_rreg got %0d/%0d want 3/4", bus.rf_rreg1, bus.rf_rreg2); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h11 || bus.out_b !== 64'h22 || bus.out_rd !== 5'd10) begin
      n_fail++; $display("FAIL basic_bundle got v=%0b a=%h b=%h rd=%0d want 1/11/22/10", bus.out_valid, bus.out_a, bus.out_b, bus.out_rd); end
    @(negedge clk); idle_inputs(); tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_r31();
    @(negedge clk);
    idle_inputs();
    issue(5'd31, 5'd2, 5'd0, 0, 64'hFFFF, 64'h5);
    bus.wb_valid = 1; bus.wb_rd = 5'd31; bus.wb_data = 64'hDEAD;
    #1;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL r31_rf_we got %0b want 0", bus.rf_we); end
    tick();
    n_checks++; if (bus.out_a !== 64'd0 || bus.out_b !== 64'h5) begin
      n_fail++; $display("FAIL r31_operands got a=%h b=%h want 0/5", bus.out_a, bus.out_b); end
    n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL r31_wb_err got %0b want 0", bus.wb_err); end
    @(negedge clk); idle_inputs(); tick();
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    issue(5'd0, 5'd0, 5'd5, 1, 64'h1, 64'h2);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_inputs();
      issue(5'd5, 5'd0, 5'd0, 0, 64'h1234, 64'h0);
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bypass_stall%0d got %0b want 0", i, bus.in_ready); end
      tick();
    end
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 64'hABCD;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_wdata !== 64'hABCD) begin
      n_fail++; $display("FAIL bypass_wb_cycle got ready=%0b we=%0b wdata=%h want 1/1/abcd", bus.in_ready, bus.rf_we, bus.rf_wdata); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hABCD) begin
      n_fail++; $display("FAIL bypass_out_a got v=%0b a=%h want 1/abcd", bus.out_valid, bus.out_a); end
    n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL bypass_wb_err got %0b want 0", bus.wb_err); end
    @(negedge clk); idle_inputs(); tick();
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle_inputs();
    issue(5'd1, 5'd2, 5'd8, 0, 64'hA1, 64'hB2);
    bus.out_ready = 0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hA1) begin
      n_fail++; $display("FAIL stall_load got v=%0b a=%h want 1/a1", bus.out_valid, bus.out_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(5'd3, 5'd4, 5'd9, 0, 64'hC3, 64'hD4);
      bus.out_ready = 0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got %0b want 0", i, bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hA1 || bus.out_b !== 64'hB2 || bus.out_rd !== 5'd8) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%0b a=%h b=%h rd=%0d want 1/a1/b2/8", i, bus.out_valid, bus.out_a, bus.out_b, bus.out_rd); end
    end
    @(negedge clk);
    bus.out_ready = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %0b want 1", bus.in_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hC3 || bus.out_b !== 64'hD4 || bus.out_rd !== 5'd9) begin
      n_fail++; $display("FAIL stall_next got v=%0b a=%h b=%h rd=%0d want 1/c3/d4/9", bus.out_valid, bus.out_a, bus.out_b, bus.out_rd); end
    @(negedge clk); idle_inputs(); tick();
  endtask

  task automatic test_same_edge();
    @(negedge clk); idle_inputs(); issue(5'd0, 5'd0, 5'd7, 1, 64'h0, 64'h0); tick();
    @(negedge clk);
    issue(5'd0, 5'd0, 5'd7, 1, 64'h0, 64'h0);
    bus.wb_valid = 1; bus.wb_rd = 5'd7; bus.wb_data = 64'h70;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL same_edge_ready got %0b want 1", bus.in_ready); end
    tick();
    @(negedge clk);
    idle_inputs();
    issue(5'd7, 5'd0, 5'd0, 0, 64'h1, 64'h0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL same_edge_busy7 got ready=%0b want 0", bus.in_ready); end
    n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL same_edge_wb_err got %0b want 0", bus.wb_err); end
    tick();
    @(negedge clk);
    bus.wb_valid = 1; bus.wb_rd = 5'd7; bus.wb_data = 64'h77;
    tick();
    n_checks++; if (bus.out_a !== 64'h77) begin n_fail++; $display("FAIL same_edge_bypass got %h want 77", bus.out_a); end
    @(negedge clk);
    idle_inputs();
    bus.wb_valid = 1; bus.wb_rd = 5'd9; bus.wb_data = 64'h99;
    #1;
    n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 5'd9) begin
      n_fail++; $display("FAIL idle_wb_write got we=%0b wreg=%0d want 1/9", bus.rf_we, bus.rf_wreg); end
    tick();
    n_checks++; if (bus.wb_err !== 1'b1) begin n_fail++; $display("FAIL idle_wb_err got %0b want 1", bus.wb_err); end
    @(negedge clk); idle_inputs(); tick(); tick();
    n_checks++; if (bus.wb_err !== 1'b1) begin n_fail++; $display("FAIL wb_err_sticky got %0b want 1", bus.wb_err); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle_inputs();
    issue(5'd0, 5'd0, 5'd5, 1, 64'h3, 64'h4);
    bus.out_ready = 0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %0b want 1", bus.out_valid); end
    @(negedge clk);
    idle_inputs(); bus.out_ready = 0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_a !== 64'd0 || bus.out_rd !== 5'd0 || bus.wb_err !== 1'b0) begin
      n_fail++; $display("FAIL areset_clear got v=%0b a=%h rd=%0d err=%0b want zeros", bus.out_valid, bus.out_a, bus.out_rd, bus.wb_err); end
    @(negedge clk); reset = 1'b0;
    issue(5'd5, 5'd0, 5'd0, 0, 64'h55, 64'h0);
    bus.out_ready = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_busy5_cleared got %0b want 1", bus.in_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h55) begin
      n_fail++; $display("FAIL areset_accept got v=%0b a=%h want 1/55", bus.out_valid, bus.out_a); end
    @(negedge clk); idle_inputs(); tick();
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic test_random();
    int cand[$];
    bit exp_rdy;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_rs1    = pick_reg();
      bus.in_rs2    = pick_reg();
      bus.in_rd     = pick_reg();
      bus.in_has_rd = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.rf_rdata1 = {$urandom, $urandom};
      bus.rf_rdata2 = {$urandom, $urandom};
      bus.wb_data   = {$urandom, $urandom};
      bus.wb_valid  = ($urandom_range(0, 9) < 4);
      cand.delete();
      for (int i = 0; i < 32; i++) if (m_busy[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8)
        bus.wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        bus.wb_rd = pick_reg();
      #1;
      exp_rdy = m_ready();
      n_checks++; if (bus.in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got %0b want %0b", n, bus.in_ready, exp_rdy); end
      n_checks++; if (bus.rf_we !== (bus.wb_valid && bus.wb_rd != 5'd31) || bus.rf_rreg1 !== bus.in_rs1) begin
        n_fail++; $display("FAIL rand_rf cyc=%0d got we=%0b rreg1=%0d", n, bus.rf_we, bus.rf_rreg1); end
      tick();
      n_checks++; if (bus.out_valid !== m_valid || bus.wb_err !== m_err) begin
        n_fail++; $display("FAIL rand_state cyc=%0d got v=%0b err=%0b want %0b/%0b", n, bus.out_valid, bus.wb_err, m_valid, m_err); end
      if (m_valid) begin
        n_checks++; if (bus.out_a !== m_a || bus.out_b !== m_b || bus.out_rd !== m_rd) begin
          n_fail++; $display("FAIL rand_bundle cyc=%0d got a=%h b=%h rd=%0d want %h/%h/%0d", n, bus.out_a, bus.out_b, bus.out_rd, m_a, m_b, m_rd); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_r31();
    test_bypass();
    test_stall();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
